// File: rtl/grid_stream_reader_pkg.sv
// rtl/grid_stream_reader_pkg.sv - shared types and constants for grid_stream_reader
package grid_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 2;

  // FIFO occupancy one cycle from now, counting the read whose data lands this cycle
  function automatic int fifo_level_next(input logic [1:0] count, input logic inflight,
                                         input logic pop);
    return int'(count) + int'(inflight) - int'(pop);
  endfunction

endpackage

// File: rtl/grid_stream_reader_skid_fifo2.sv
// rtl/grid_stream_reader_skid_fifo2.sv - two-entry FIFO that absorbs RAM read latency
module skid_fifo2
  import grid_stream_reader_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_pop;

  assign do_pop = pop && (count != 2'd0);
  assign head   = mem[rd_ptr];

  // Storage, pointers and occupancy; push and pop in one cycle leave count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/grid_stream_reader.sv
// rtl/grid_stream_reader.sv - raster-order grid RAM reader with valid/ready output (optional GRID_STREAM_READER_COORD_EN)
module grid_stream_reader
  import grid_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 10,
  parameter int NX            = 16,
  parameter int NY            = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_address,
  output logic [ADDRESS_WIDTH-1:0] read_address,
  input  logic [DATA_WIDTH-1:0]    ram_data,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
`ifdef GRID_STREAM_READER_COORD_EN
  ,
  output logic [((NX > 1) ? $clog2(NX) : 1)-1:0] out_x,
  output logic [((NY > 1) ? $clog2(NY) : 1)-1:0] out_y
`endif
);

  localparam int LAST_I = NX * NY - 1;
  localparam logic [ADDRESS_WIDTH:0] LAST_INDEX = LAST_I[ADDRESS_WIDTH:0];
`ifdef GRID_STREAM_READER_COORD_EN
  localparam int XW = (NX > 1) ? $clog2(NX) : 1;
  localparam int YW = (NY > 1) ? $clog2(NY) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(NX - 1);
`endif

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
`ifdef GRID_STREAM_READER_COORD_EN
    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
`endif
  } payload_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] base_q;
  logic [ADDRESS_WIDTH:0]   index;
  logic                     inflight;
  logic                     inflight_last;
  logic [1:0]               count;
  logic                     pop;
  logic                     issue;
  payload_t                 push_payload;
  payload_t                 head;
`ifdef GRID_STREAM_READER_COORD_EN
  logic [XW-1:0]            x_cnt;
  logic [YW-1:0]            y_cnt;
  logic [XW-1:0]            inflight_x;
  logic [YW-1:0]            inflight_y;
`endif

  // Issue only when the data returning next cycle is guaranteed a FIFO slot
  always_comb begin
    pop               = (count != 2'd0) && out_ready;
    issue             = (state == READ) && (fifo_level_next(count, inflight, pop) < FIFO_DEPTH);
    push_payload      = '0;
    push_payload.data = ram_data;
    push_payload.last = inflight_last;
`ifdef GRID_STREAM_READER_COORD_EN
    push_payload.x    = inflight_x;
    push_payload.y    = inflight_y;
`endif
  end

  assign out_valid = (count != 2'd0);
  assign out_data  = head.data;
  assign out_last  = head.last && out_valid;
`ifdef GRID_STREAM_READER_COORD_EN
  assign out_x     = head.x;
  assign out_y     = head.y;
`endif

  skid_fifo2 #(.WIDTH($bits(payload_t))) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (push_payload),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  // Sweep sequencing: address generation, in-flight tracking, busy/done
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      base_q        <= '0;
      index         <= '0;
      read_address  <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done          <= 1'b0;
      inflight      <= issue;
      inflight_last <= issue && (index == LAST_INDEX);
      if (done) busy <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q       <= base_address;
            index        <= '0;
            read_address <= base_address;
            busy         <= 1'b1;
            state        <= READ;
          end
        end
        READ: begin
          if (issue) begin
            if (index == LAST_INDEX) begin
              state <= DRAIN;
            end else begin
              index        <= index + 1'b1;
              read_address <= base_q + index[ADDRESS_WIDTH-1:0] + ADDRESS_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          if (fifo_level_next(count, inflight, pop) == 0) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GRID_STREAM_READER_COORD_EN
  // Raster coordinates of the next read, tagged onto the read as it issues
  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt      <= '0;
      y_cnt      <= '0;
      inflight_x <= '0;
      inflight_y <= '0;
    end else begin
      if (state == IDLE && start) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (issue) begin
        if (x_cnt == X_LAST) begin
          x_cnt <= '0;
          y_cnt <= y_cnt + YW'(1);
        end else begin
          x_cnt <= x_cnt + XW'(1);
        end
      end
      if (issue) begin
        inflight_x <= x_cnt;
        inflight_y <= y_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_grid_stream_reader.sv
// tb/tb_grid_stream_reader.sv - randomized scoreboard bench for grid_stream_reader
module tb_grid_stream_reader;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int NX = 4;
  localparam int NY = 3;
  localparam int N  = NX * NY;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_address;
  logic [AW-1:0] read_address;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;
`ifdef GRID_STREAM_READER_COORD_EN
  logic [1:0]    out_x;
  logic [1:0]    out_y;
`endif

  grid_stream_reader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NX(NX), .NY(NY)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_address (base_address),
    .read_address (read_address),
    .ram_data     (ram_data),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done)
`ifdef GRID_STREAM_READER_COORD_EN
    ,
    .out_x        (out_x),
    .out_y        (out_y)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [1 << AW];
  always @(posedge clk) ram_data <= mem[read_address];

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            x;
    int            y;
  } exp_t;
  exp_t sbq[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t0 = 0;
  int ready_mode = 0;
  int done_cnt = 0;
  int accept_cnt = 0;
  int first_valid_cyc = -1;
  int done_cyc = -1;
  int last_cyc = -1;
  logic busy_at_done = 1'b0;
  logic busy_after_done = 1'b1;
  logic prev_done = 1'b0;
  logic stall_pend = 1'b0;
  logic [DW-1:0] stall_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        2: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops expectations on each handshake, checks stall stability
  always @(negedge clk) begin
    if (rst) begin
      stall_pend = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_done) busy_after_done = busy;
      prev_done = done;
      if (done) begin
        done_cnt++;
        done_cyc     = cyc - t0;
        busy_at_done = busy;
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc - t0;
      if (stall_pend) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'(out_data), 64'(stall_data));
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("unexpected_sample", 64'(out_data), 64'hDEAD_0000_0000_0000);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          accept_cnt++;
          check("sample_data", 64'(out_data), 64'(e.data));
          check("sample_last", 64'(out_last), 64'(e.last));
          if (out_last) last_cyc = cyc - t0;
`ifdef GRID_STREAM_READER_COORD_EN
          check("sample_x", 64'(out_x), 64'(e.x));
          check("sample_y", 64'(out_y), 64'(e.y));
`endif
        end
      end
      stall_pend = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  task automatic push_sweep(input int base);
    for (int k = 0; k < N; k++) begin
      exp_t e;
      e.data = mem[(base + k) % (1 << AW)];
      e.last = (k == N - 1);
      e.x    = k % NX;
      e.y    = k / NX;
      sbq.push_back(e);
    end
  endtask

  task automatic pulse_start(input int base);
    @(posedge clk);
    #1;
    start        = 1'b1;
    base_address = AW'(base);
    t0           = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_start(input int base);
    push_sweep(base);
    first_valid_cyc = -1;
    accept_cnt      = 0;
    pulse_start(base);
  endtask

  task automatic wait_done(input int budget);
    int dc;
    int i;
    dc = done_cnt;
    i  = 0;
    while (done_cnt == dc && i < budget) begin
      @(posedge clk);
      i++;
    end
    check("done_timeout", 64'(done_cnt != dc), 64'd1);
    repeat (3) @(posedge clk);
    check("queue_empty", 64'(sbq.size()), 64'd0);
  endtask

  task automatic wait_accepts(input int n);
    int i;
    i = 0;
    while (accept_cnt < n && i < 200) begin
      @(negedge clk);
      i++;
    end
    check("accept_timeout", 64'(accept_cnt >= n), 64'd1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
  endtask

  initial begin
    int dc;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
    rst = 1'b1;
    start = 1'b0;
    base_address = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_read_address", 64'(read_address), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    #1 rst = 1'b0;

    // Full-rate sweep: latency and done timing
    ready_mode = 0;
    run_start(32'h010);
    wait_done(100);
    check("first_valid_cycle", 64'(first_valid_cyc), 64'd3);
    check("last_cycle", 64'(last_cyc), 64'(N + 2));
    check("done_cycle", 64'(done_cyc), 64'(N + 3));
    check("busy_at_done", 64'(busy_at_done), 64'd1);
    check("busy_after_done", 64'(busy_after_done), 64'd0);

    // Alternating backpressure
    ready_mode = 1;
    run_start(32'h010);
    wait_done(200);

    // Address wrap-around with random data and random backpressure
    fill_random();
    ready_mode = 2;
    run_start(32'h3FC);
    wait_done(300);

    // Second start mid-sweep must be ignored
    fill_random();
    ready_mode = 0;
    dc = done_cnt;
    run_start(32'h123);
    wait_accepts(5);
    pulse_start(32'h200);
    wait_done(200);
    repeat (20) @(posedge clk);
    check("single_done", 64'(done_cnt - dc), 64'd1);

    // Reset mid-sweep, then a clean sweep
    fill_random();
    run_start(32'h040);
    wait_accepts(6);
    ready_mode = 3;
    @(posedge clk);
    #1;
    rst = 1'b1;
    sbq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    ready_mode = 0;
    repeat (10) @(posedge clk);
    run_start(32'h040);
    wait_done(200);

    // Randomized sweeps
    for (int s = 0; s < 8; s++) begin
      fill_random();
      ready_mode = $urandom_range(0, 2);
      run_start($urandom_range(0, (1 << AW) - 1));
      wait_done(300);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
